mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM stage of the 5-stage RV32I pipeline: consumes EX/MEM register outputs, performs load/store on a
//  variable-latency data-memory bus (req/ack), aligns/extends load data, and registers results into MEM/WB.
//  Drives stall_mem so IF..EX/MEM hold while a bus access is outstanding; bubbles MEM/WB during stall.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in WAIT without ack before access aborts with bus error (>=2)
//  CNT_W           5   timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  MemtoReg_mem   in   1   from EX/MEM: WB selects load data
//  RegWrite_mem   in   1   from EX/MEM: rd write enable
//  MemWrite_mem   in   1   from EX/MEM: store
//  MemRead_mem    in   1   from EX/MEM: load
//  funct3_mem     in   3   from EX/MEM: size/sign (000 B,001 H,010 W,100 BU,101 HU)
//  ALUResult_mem  in   32  effective address / ALU result
//  MemWriteData_mem in 32  store data (rs2, unaligned in low bits)
//  rdAddr_mem     in   5   destination register
//  dmem_req       out  1   bus request, held until ack or abort
//  dmem_we        out  1   1=write
//  dmem_addr      out  32  word-aligned address {ALUResult_mem[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_rdata     in   32  read word, valid with dmem_ack
//  dmem_ack       in   1   access complete (may arrive same cycle as req)
//  stall_mem      out  1   upstream hold
//  MemtoReg_wb, RegWrite_wb  out 1   MEM/WB controls
//  ALUResult_wb   out  32  ; MemReadData_wb out 32 aligned/extended load data ; rdAddr_wb out 5
//  misalign_wb    out  1   1-cycle flag: misaligned access dropped ; buserr_wb out 1 timeout flag
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counter=0. No reset-release glitch on dmem_req.
//  - acc = MemRead_mem|MemWrite_mem; mis = acc & (H/HU & addr[0] | W & addr[1:0]!=0).
//  - FSM IDLE: acc&~mis -> dmem_req=1 combinationally; ack same cycle = zero-wait, no stall;
//    else stall_mem=1, go WAIT, cnt=1. WAIT: req held, bus outputs stable (from held EX/MEM inputs);
//    ack -> IDLE, stall_mem=0 that cycle; cnt==TIMEOUT_CYCLES & ~ack -> IDLE, abort. Ack beats timeout.
//  - stall_mem = dmem_req & ~dmem_ack & ~abort (combinational).
//  - MEM/WB capture on every edge: if stall_mem -> bubble (RegWrite_wb=0, MemtoReg_wb=0, flags 0,
//    data regs hold); else latch EX/MEM fields, MemReadData_wb=align(dmem_rdata).
//  - mis: no bus request, no stall; captured with RegWrite_wb=0, misalign_wb=1 for one cycle.
//  - abort: captured with RegWrite_wb=0, buserr_wb=1 for one cycle; store discarded.
//  - Stores: B be=1<<a[1:0], wdata={4{d[7:0]}}; H be=a[1]?1100:0011, wdata={2{d[15:0]}}; W be=1111.
//  - Loads: select byte/half lane by a[1:0]; B/H sign-extend, BU/HU zero-extend; be=1111 on reads.
//  - Non-memory instr: pass-through, 1-cycle latency, no req. dmem_ack while no req: ignored.
//  - Reset mid-WAIT: req drops immediately, FSM IDLE; bus must tolerate the abandoned request.
//  - Both MemRead and MemWrite set is illegal upstream; treat as write.
// STRUCTURE
//  - riscv_pkg: funct3 size encodings, FSM state encodings (IDLE/WAIT), WORD_W=32.
//  - Sub-module load_align (combinational): rdata, a[1:0], funct3 -> 32-bit extended load value.
//  - Top: FSM + timeout counter, store lane logic, MEM/WB register with bubble insertion.
// TESTING
//  1 LW a=0x100, ack same cycle, rdata=0xDEADBEEF -> no stall, next cycle MemReadData_wb=0xDEADBEEF, RegWrite_wb=1.
//  2 LB a=0x103, rdata=0x80FF_0000, ack after 3 cycles -> stall_mem=1 exactly 3 cycles, 3 bubbles, then data=0xFFFFFF80.
//  3 SH a=0x102, d=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
//  4 LW a=0x101 -> no dmem_req, misalign_wb=1 one cycle, RegWrite_wb=0.
//  5 LW, no ack -> stall TIMEOUT_CYCLES cycles, buserr_wb=1, RegWrite_wb=0; ack on timeout cycle -> normal completion.
//  6 Assert rst_n=0 during WAIT -> dmem_req=0, stall_mem=0, all *_wb=0 same cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and widths for the MEM stage.
package riscv_pkg;

  localparam int unsigned WORD_W = 32;

  // funct3 size/sign encodings for loads and stores
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Bus access FSM states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsuState_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Lane selection and sign/zero extension of a read word.
module load_align
  import riscv_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        byteOff,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] loadVal
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the addressed byte/half lane and extend it to a full word
  always_comb begin
    byteSel = rdata[7:0];
    halfSel = byteOff[1] ? rdata[31:16] : rdata[15:0];
    loadVal = rdata;
    case (byteOff)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    case (funct3)
      F3_B:    loadVal = {{24{byteSel[7]}}, byteSel};
      F3_BU:   loadVal = {24'h000000, byteSel};
      F3_H:    loadVal = {{16{halfSel[15]}}, halfSel};
      F3_HU:   loadVal = {16'h0000, halfSel};
      default: loadVal = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: data-memory bus FSM with timeout, store lane steering, MEM/WB register.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  logic        MemWrite_mem,
  input  logic        MemRead_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemWriteData_mem,
  input  logic [4:0]  rdAddr_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        MemtoReg_wb,
  output logic        RegWrite_wb,
  output logic [31:0] ALUResult_wb,
  output logic [31:0] MemReadData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        misalign_wb,
  output logic        buserr_wb
);

  lsuState_e        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             acc, mis, accessOk, sizeH, sizeW;
  logic             reqC, abortC;
  logic [3:0]       beC;
  logic [31:0]      wdataC;
  logic [31:0]      loadVal;

  // Access classification and alignment check
  always_comb begin
    acc      = MemRead_mem | MemWrite_mem;
    sizeH    = (funct3_mem == F3_H) | (funct3_mem == F3_HU);
    sizeW    = (funct3_mem == F3_W);
    mis      = acc & ((sizeH & ALUResult_mem[0]) | (sizeW & (ALUResult_mem[1:0] != 2'b00)));
    accessOk = acc & ~mis;
  end

  // FSM and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next state, request and abort decode; ack wins over timeout
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    reqC   = 1'b0;
    abortC = 1'b0;
    case (stateQ)
      IDLE: begin
        if (accessOk) begin
          reqC = 1'b1;
          if (!dmem_ack) begin
            stateD = WAIT;
            cntD   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        reqC = 1'b1;
        if (dmem_ack) begin
          stateD = IDLE;
          cntD   = '0;
        end else if (cntQ == CNT_W'(TIMEOUT_CYCLES)) begin
          abortC = 1'b1;
          stateD = IDLE;
          cntD   = '0;
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = '0;
      end
    endcase
  end

  // Store byte enables and lane-replicated write data; reads enable all lanes
  always_comb begin
    beC    = 4'b1111;
    wdataC = MemWriteData_mem;
    if (MemWrite_mem) begin
      case (funct3_mem)
        F3_B, F3_BU: begin
          beC    = 4'b0001 << ALUResult_mem[1:0];
          wdataC = {4{MemWriteData_mem[7:0]}};
        end
        F3_H, F3_HU: begin
          beC    = ALUResult_mem[1] ? 4'b1100 : 4'b0011;
          wdataC = {2{MemWriteData_mem[15:0]}};
        end
        default: begin
          beC    = 4'b1111;
          wdataC = MemWriteData_mem;
        end
      endcase
    end
  end

  // Bus outputs, forced low while reset is asserted so an abandoned request drops at once
  always_comb begin
    dmem_req   = reqC & rst_n;
    dmem_we    = reqC & rst_n & MemWrite_mem;
    dmem_addr  = {32{rst_n}} & {ALUResult_mem[31:2], 2'b00};
    dmem_be    = {4{rst_n}} & beC;
    dmem_wdata = {32{rst_n}} & wdataC;
    stall_mem  = dmem_req & ~dmem_ack & ~abortC;
  end

  load_align uLoadAlign (
    .rdata   (dmem_rdata),
    .byteOff (ALUResult_mem[1:0]),
    .funct3  (funct3_mem),
    .loadVal (loadVal)
  );

  // MEM/WB register: bubble while stalled, squash writeback on misalign or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemtoReg_wb    <= 1'b0;
      RegWrite_wb    <= 1'b0;
      ALUResult_wb   <= '0;
      MemReadData_wb <= '0;
      rdAddr_wb      <= '0;
      misalign_wb    <= 1'b0;
      buserr_wb      <= 1'b0;
    end else if (stall_mem) begin
      MemtoReg_wb <= 1'b0;
      RegWrite_wb <= 1'b0;
      misalign_wb <= 1'b0;
      buserr_wb   <= 1'b0;
    end else begin
      MemtoReg_wb    <= MemtoReg_mem;
      RegWrite_wb    <= RegWrite_mem & ~mis & ~abortC;
      ALUResult_wb   <= ALUResult_mem;
      MemReadData_wb <= loadVal;
      rdAddr_wb      <= rdAddr_mem;
      misalign_wb    <= mis;
      buserr_wb      <= abortC;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

  logic        clk, rst_n;
  logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem, MemRead_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] ALUResult_mem, MemWriteData_mem;
  logic [4:0]  rdAddr_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack, stall_mem;
  logic        MemtoReg_wb, RegWrite_wb, misalign_wb, buserr_wb;
  logic [31:0] ALUResult_wb, MemReadData_wb;
  logic [4:0]  rdAddr_wb;

  int nCmp = 0;
  int nErr = 0;
  int nStall;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
    .MemWrite_mem(MemWrite_mem), .MemRead_mem(MemRead_mem),
    .funct3_mem(funct3_mem), .ALUResult_mem(ALUResult_mem),
    .MemWriteData_mem(MemWriteData_mem), .rdAddr_mem(rdAddr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_mem(stall_mem),
    .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb),
    .ALUResult_wb(ALUResult_wb), .MemReadData_wb(MemReadData_wb),
    .rdAddr_wb(rdAddr_wb), .misalign_wb(misalign_wb), .buserr_wb(buserr_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw, input logic m2r,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    MemRead_mem      = mr;
    MemWrite_mem     = mw;
    RegWrite_mem     = rw;
    MemtoReg_mem     = m2r;
    funct3_mem       = f3;
    ALUResult_mem    = a;
    MemWriteData_mem = wd;
    rdAddr_mem       = rd;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd3);
    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_regwrite_wb", 32'(RegWrite_wb), 32'd0);
    chk("rst_alu_wb", ALUResult_wb, 32'h0);
    nop();
    nextCyc();
    rst_n = 1'b1;
    nextCyc();

    // LW zero-wait
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd5);
    dmem_rdata = 32'hDEADBEEF;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_stall", 32'(stall_mem), 32'd0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", 32'(dmem_be), 32'hF);
    chk("lw_we", 32'(dmem_we), 32'd0);
    nextCyc();
    nop();
    @(negedge clk);
    chk("lw_data_wb", MemReadData_wb, 32'hDEADBEEF);
    chk("lw_regwrite_wb", 32'(RegWrite_wb), 32'd1);
    chk("lw_rd_wb", 32'(rdAddr_wb), 32'd5);
    chk("lw_m2r_wb", 32'(MemtoReg_wb), 32'd1);

    // LB with ack after 3 stall cycles
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h103, 32'h0, 5'd6);
    dmem_rdata = 32'h80FF_0000;
    nStall = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      @(negedge clk);
      if (stall_mem) nStall++;
      if (i > 0) chk("lb_bubble", 32'(RegWrite_wb), 32'd0);
      if (i == 2) chk("lb_req_held", 32'(dmem_req), 32'd1);
      nextCyc();
    end
    nop();
    chk("lb_stall_cycles", 32'(nStall), 32'd3);
    @(negedge clk);
    chk("lb_data_wb", MemReadData_wb, 32'hFFFFFF80);
    chk("lb_regwrite_wb", 32'(RegWrite_wb), 32'd1);

    // LH / LHU at upper half
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 32'h102, 32'h0, 5'd8);
    dmem_rdata = 32'h8001_1234;
    dmem_ack = 1'b1;
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h102, 32'h0, 5'd9);
    @(negedge clk);
    chk("lh_data_wb", MemReadData_wb, 32'hFFFF8001);
    nextCyc();
    nop();
    @(negedge clk);
    chk("lhu_data_wb", MemReadData_wb, 32'h00008001);

    // SH / SB lane steering
    nextCyc();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_addr", dmem_addr, 32'h100);
    nextCyc();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h101, 32'h000000EF, 5'd0);
    @(negedge clk);
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hEFEFEFEF);

    // Misaligned LW
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 5'd4);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(stall_mem), 32'd0);
    nextCyc();
    nop();
    @(negedge clk);
    chk("mis_flag_wb", 32'(misalign_wb), 32'd1);
    chk("mis_regwrite_wb", 32'(RegWrite_wb), 32'd0);
    nextCyc();
    @(negedge clk);
    chk("mis_flag_clear", 32'(misalign_wb), 32'd0);

    // LW timeout abort
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd10);
    dmem_ack = 1'b0;
    nStall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_mem) break;
      nStall++;
      nextCyc();
    end
    chk("to_stall_cycles", 32'(nStall), 32'd16);
    nextCyc();
    nop();
    @(negedge clk);
    chk("to_buserr_wb", 32'(buserr_wb), 32'd1);
    chk("to_regwrite_wb", 32'(RegWrite_wb), 32'd0);
    nextCyc();
    @(negedge clk);
    chk("to_buserr_clear", 32'(buserr_wb), 32'd0);

    // Ack on the timeout cycle completes normally
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h204, 32'h0, 5'd11);
    dmem_rdata = 32'h11223344;
    nStall = 0;
    for (int i = 0; i < 17; i++) begin
      dmem_ack = (i == 16);
      @(negedge clk);
      if (stall_mem) nStall++;
      nextCyc();
    end
    nop();
    chk("ackto_stall_cycles", 32'(nStall), 32'd16);
    @(negedge clk);
    chk("ackto_buserr_wb", 32'(buserr_wb), 32'd0);
    chk("ackto_regwrite_wb", 32'(RegWrite_wb), 32'd1);
    chk("ackto_data_wb", MemReadData_wb, 32'h11223344);

    // Reset asserted during WAIT
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd7);
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rw_stall_pre", 32'(stall_mem), 32'd1);
    nextCyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_stall", 32'(stall_mem), 32'd0);
    chk("rw_alu_wb", ALUResult_wb, 32'h0);
    chk("rw_data_wb", MemReadData_wb, 32'h0);
    chk("rw_rd_wb", 32'(rdAddr_wb), 32'd0);
    nop();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_idle_noreq", 32'(dmem_req), 32'd0);
    nextCyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 32'h105, 32'h0, 5'd12);
    dmem_rdata = 32'h0000_9A00;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall_mem), 32'd0);
    nextCyc();
    nop();
    @(negedge clk);
    chk("lbu_data_wb", MemReadData_wb, 32'h0000009A);
    chk("lbu_rd_wb", 32'(rdAddr_wb), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
